// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and bit-timing helper shared by the UART receive path
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  function automatic int unsigned uart_timing(input int unsigned clk_hz, input int unsigned baud, input logic half);
    return half ? (clk_hz / baud) / 2 : clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO with wrap-around pointers and an extra bit separating full from empty
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] mem_q [DEPTH];
  logic pop, wr_en;
  assign valid = wr_q != rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop = valid && ready;
  assign wr_en = push && (!full || pop);
  assign data = valid ? mem_q[rd_q[AW-1:0]] : 8'h00;
  // advance pointers on accepted push and on pop
  always_comb begin
    wr_d = wr_q + (AW+1)'(wr_en);
    rd_d = rd_q + (AW+1)'(pop);
  end
  // pointer registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  // storage needs no reset: entries are only visible behind valid
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q[AW-1:0]] <= push_data;
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with output buffer (FIFO when UART_RX_FIFO_EN, else one holding register)
module uart_rx_buffered #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 10_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_err,
  output logic       overflow
);
  import uart_pkg::*;
  localparam logic [15:0] BT_M1 = 16'(uart_timing(CLOCK_FREQ, BAUD_RATE, 1'b0) - 1);
  localparam logic [15:0] HT = 16'(uart_timing(CLOCK_FREQ, BAUD_RATE, 1'b1));
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic rx, push, pop, full;
  assign rx = sync_q[1];
  assign sync_d = {sync_q[0], serial_in};
  assign pop = data_out_valid && data_out_ready;
  assign frame_err = frame_err_q;
  assign overflow = overflow_q;
  assign overflow_d = push && full && !pop;
  // receive FSM: counters restart at each sample so samples stay one bit time apart
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 16'd1;
    bit_d = bit_q;
    shift_d = shift_q;
    push = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) begin
          state_d = START;
          bit_d = '0;
        end
      end
      START:
        if (cnt_q == HT) begin
          cnt_d = '0;
          state_d = rx ? IDLE : DATA;
        end
      DATA:
        if (cnt_q == BT_M1) begin
          cnt_d = '0;
          shift_d = {rx, shift_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      STOP:
        if (cnt_q == BT_M1) begin
          cnt_d = '0;
          push = rx;
          frame_err_d = !rx;
          state_d = rx ? IDLE : WAIT_HIGH;
        end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // receiver state, synchronizer and status pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sync_q <= 2'b11;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      frame_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q <= overflow_d;
    end
`ifdef UART_RX_FIFO_EN
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(shift_q),
    .ready(data_out_ready),
    .data(data_out),
    .valid(data_out_valid),
    .full(full)
  );
`else
  logic [7:0] hold_q, hold_d;
  logic valid_q, valid_d;
  assign full = valid_q;
  assign data_out = hold_q;
  assign data_out_valid = valid_q;
  // single holding register: load when empty or being popped, else keep
  always_comb begin
    hold_d = (push && (!valid_q || pop)) ? shift_q : hold_q;
    valid_d = (push && (!valid_q || pop)) ? 1'b1 : (pop ? 1'b0 : valid_q);
  end
  // holding register state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_q <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      valid_q <= valid_d;
    end
`endif
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed bench for uart_rx_buffered (UART_RX_FIFO_EN selects depth-8 or single-register expectations)
module tb_uart_rx_buffered;
  import uart_pkg::*;
`ifdef UART_RX_FIFO_EN
  localparam int N_OVF = 9;
`else
  localparam int N_OVF = 2;
`endif
  logic clk = 1'b0, rst = 1'b1, serial_in = 1'b1, data_out_ready = 1'b1;
  logic [7:0] data_out;
  logic data_out_valid, frame_err, overflow;
  int n_checks = 0, n_fails = 0;
  int fe_cnt = 0, ov_cnt = 0, v_cnt = 0;
  logic [7:0] rxq [$];
  int base, fe0, ov0, v0;

  uart_rx_buffered dut (
    .clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_out_valid) v_cnt++;
    if (data_out_valid && data_out_ready) rxq.push_back(data_out);
    if (frame_err) fe_cnt++;
    if (overflow) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    serial_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int stop_len);
    hold(1'b0, 5);
    for (int i = 0; i < 8; i++) hold(b[i], 5);
    hold(stop, stop_len);
    hold(1'b1, 10);
  endtask

  task automatic snap();
    base = rxq.size();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    v0 = v_cnt;
  endtask

  initial begin
    #1;
    check("rst_valid", 32'(data_out_valid), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_fe", 32'(frame_err), 0);
    check("rst_ov", 32'(overflow), 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    hold(1'b1, 5);

    snap();
    send(8'h78, 1'b1, 5);
    check("b78_count", 32'(rxq.size() - base), 1);
    if (rxq.size() > base) check("b78_data", 32'(rxq[base]), 32'h78);
    check("b78_valid_cycles", 32'(v_cnt - v0), 1);
    check("b78_fe", 32'(fe_cnt - fe0), 0);
    check("b78_ov", 32'(ov_cnt - ov0), 0);

    snap();
    hold(1'b0, 1);
    hold(1'b1, 20);
    check("glitch_push", 32'(rxq.size() - base), 0);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));

    snap();
    send(8'h55, 1'b0, 20);
    check("fe_pulses", 32'(fe_cnt - fe0), 1);
    check("fe_push", 32'(rxq.size() - base), 0);
    check("fe_state", 32'(dut.state_q), 32'(IDLE));
    snap();
    send(8'h31, 1'b1, 5);
    check("b31_count", 32'(rxq.size() - base), 1);
    if (rxq.size() > base) check("b31_data", 32'(rxq[base]), 32'h31);

    data_out_ready = 1'b0;
    snap();
    for (int i = 1; i < N_OVF; i++) send(8'(i), 1'b1, 5);
    check("ovf_before_full", 32'(ov_cnt - ov0), 0);
    send(8'(N_OVF), 1'b1, 5);
    check("ovf_pulses", 32'(ov_cnt - ov0), 1);
    check("ovf_head_valid", 32'(data_out_valid), 1);
    check("ovf_head_data", 32'(data_out), 32'h01);
    data_out_ready = 1'b1;
    hold(1'b1, 20);
    check("drain_count", 32'(rxq.size() - base), 32'(N_OVF - 1));
    for (int i = 0; i < N_OVF - 1; i++)
      if (rxq.size() > base + i) check($sformatf("drain_%0d", i), 32'(rxq[base + i]), 32'(i + 1));
    check("drain_valid", 32'(data_out_valid), 0);

    snap();
    hold(1'b0, 5);
    hold(1'b0, 5);
    hold(1'b1, 5);
    hold(1'b0, 5);
    serial_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(data_out_valid), 0);
    check("mid_rst_data", 32'(data_out), 0);
    check("mid_rst_fe", 32'(frame_err), 0);
    check("mid_rst_ov", 32'(overflow), 0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    hold(1'b1, 60);
    check("mid_rst_no_push", 32'(rxq.size() - base), 0);
    snap();
    send(8'h0d, 1'b1, 5);
    check("b0d_count", 32'(rxq.size() - base), 1);
    if (rxq.size() > base) check("b0d_data", 32'(rxq[base]), 32'h0d);
    check("b0d_fe", 32'(fe_cnt - fe0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
